// File: rtl/mole_rng_sched.sv
// Mole-position generator: a free-running Galois LFSR feeds rejection-sampled hole picks
// with an optional no-repeat rule and a deterministic fallback after MAX_TRIES draws.
module mole_rng_sched #(
  parameter int                N_HOLES   = 5,
  parameter int                IDX_W     = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_MOLES = 30,
  parameter int                MAX_TRIES = 8,
  parameter int                NO_REPEAT = 1
) (
  input  logic               clkGlobal,
  input  logic               resetN,
  input  logic               start,
  input  logic               tick,
  input  logic               sample,
  input  logic               hit,
  output logic [IDX_W-1:0]   holeIdx,
  output logic [N_HOLES-1:0] holeLed,
  output logic               moleValid,
  output logic [5:0]         moleCount,
  output logic               busy,
  output logic               done
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DRAW = 3'd2;
  localparam logic [2:0] S_SHOW = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [LFSR_W-1:0] lfsr;
  logic [IDX_W-1:0]  last_idx;
  logic [TRY_W-1:0]  tries;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  fallback;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W:0]    inc;
  logic              req;
  logic              cand_ok;
  logic              last_try;

  assign req  = tick | sample;
  assign cand = lfsr[IDX_W-1:0];
  assign busy = (state == S_DRAW);

  always_comb begin
    cand_ok  = ({1'b0, cand} < (IDX_W+1)'(N_HOLES)) &&
               ((NO_REPEAT == 0) || (N_HOLES == 1) || (cand != last_idx));
    inc      = {1'b0, last_idx} + 1'b1;
    fallback = (inc >= (IDX_W+1)'(N_HOLES)) ? '0 : inc[IDX_W-1:0];
    pick     = cand_ok ? cand : fallback;
    last_try = (tries == TRY_W'(MAX_TRIES - 1));
  end

  always_ff @(posedge clkGlobal or negedge resetN) begin
    if (!resetN) lfsr <= SEED;
    else         lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clkGlobal or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      holeIdx   <= '0;
      holeLed   <= '0;
      moleValid <= 1'b0;
      moleCount <= '0;
      done      <= 1'b0;
      last_idx  <= '0;
      tries     <= '0;
    end else if (start) begin
      state     <= S_WAIT;
      holeIdx   <= '0;
      holeLed   <= '0;
      moleValid <= 1'b0;
      moleCount <= '0;
      done      <= 1'b0;
      tries     <= '0;
    end else begin
      case (state)
        S_WAIT, S_SHOW: begin
          // A request outranks a same-cycle hit; both clear the shown mole.
          if (req || (state == S_SHOW && hit)) begin
            holeIdx   <= '0;
            holeLed   <= '0;
            moleValid <= 1'b0;
          end
          if (req) begin
            tries <= '0;
            if (moleCount == 6'(MAX_MOLES)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAW;
            end
          end else if (state == S_SHOW && hit) begin
            state <= S_WAIT;
          end
        end
        S_DRAW: begin
          if (cand_ok || last_try) begin
            holeIdx   <= pick;
            holeLed   <= N_HOLES'(1) << pick;
            moleValid <= 1'b1;
            last_idx  <= pick;
            moleCount <= moleCount + 6'd1;
            state     <= S_SHOW;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_rng_sched.sv
// Randomized scoreboard bench for mole_rng_sched against a behavioural draw model.
module tb_mole_rng_sched;
  localparam int NH = 5;
  localparam int MM = 30;
  localparam int MT = 8;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       start = 1'b0, tick = 1'b0, sample = 1'b0, hit = 1'b0;
  logic [2:0] holeIdx;
  logic [4:0] holeLed;
  logic       moleValid, busy, done;
  logic [5:0] moleCount;

  logic       start1 = 1'b0, tick1 = 1'b0, hit1 = 1'b0;
  logic [0:0] holeIdx1;
  logic [0:0] holeLed1;
  logic       moleValid1, busy1, done1;
  logic [5:0] moleCount1;

  mole_rng_sched u_dut (
    .clkGlobal(clk), .resetN(resetN), .start(start), .tick(tick), .sample(sample), .hit(hit),
    .holeIdx(holeIdx), .holeLed(holeLed), .moleValid(moleValid), .moleCount(moleCount),
    .busy(busy), .done(done)
  );

  mole_rng_sched #(.N_HOLES(1), .IDX_W(1), .MAX_TRIES(2)) u_one (
    .clkGlobal(clk), .resetN(resetN), .start(start1), .tick(tick1), .sample(1'b0), .hit(hit1),
    .holeIdx(holeIdx1), .holeLed(holeLed1), .moleValid(moleValid1), .moleCount(moleCount1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference: current LFSR value and cycle number
  logic [15:0] m_lfsr;
  int          cyc;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_lfsr <= 16'hACE1;
      cyc    <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      cyc    <= cyc + 1;
    end
  end

  typedef struct { int idx; int cnt; int cyc; } exp_t;
  exp_t sb[$];
  int   m_last = 0;
  int   m_cnt  = 0;
  int   prev_shown = 0;
  bit   seen[NH];

  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (moleValid && !prev_v) begin
        check("sb_entries_for_mole", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("hole_idx", int'(holeIdx), e.idx);
          check("hole_led", int'(holeLed), 1 << e.idx);
          check("mole_count", int'(moleCount), e.cnt);
          check("show_cycle", cyc, e.cyc);
          check("no_repeat", int'(int'(holeIdx) != prev_shown), 1);
          prev_shown = int'(holeIdx);
          if (holeIdx < NH) seen[holeIdx] = 1'b1;
        end
      end
      prev_v = moleValid;
    end
  end

  task automatic drop_model();
    sb.delete();
    m_last = 0;
    m_cnt = 0;
    prev_shown = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    check("start_count", int'(moleCount), 0);
    check("start_done", int'(done), 0);
  endtask

  task automatic do_hit();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    check("hit_clears_valid", int'(moleValid), 0);
    check("hit_keeps_count", int'(moleCount), m_cnt);
    check("hit_not_busy", int'(busy), 0);
  endtask

  // kind: 0 tick, 1 sample, 2 tick+sample, 3 tick+hit
  task automatic issue(input int kind);
    logic [15:0] l;
    int   pick, lat;
    bit   exp_done;
    @(negedge clk);
    tick   = (kind != 1);
    sample = (kind == 1 || kind == 2);
    hit    = (kind == 3);
    exp_done = (m_cnt == MM);
    if (!exp_done) begin
      l = lfsr_step(m_lfsr);
      pick = -1;
      lat = 0;
      for (int t = 0; t < MT; t++) begin
        if (int'(l[2:0]) < NH && int'(l[2:0]) != m_last) begin
          pick = int'(l[2:0]);
          lat = t;
          break;
        end
        if (t == MT - 1) begin
          pick = (m_last + 1) % NH;
          lat = t;
        end
        l = lfsr_step(l);
      end
      m_last = pick;
      m_cnt++;
      sb.push_back('{pick, m_cnt, cyc + 2 + lat});
    end
    @(negedge clk);
    tick = 1'b0;
    sample = 1'b0;
    hit = 1'b0;
    if (exp_done) begin
      check("round_done", int'(done), 1);
      check("done_no_mole", int'(moleValid), 0);
      check("done_count", int'(moleCount), MM);
      check("done_not_busy", int'(busy), 0);
    end else begin
      check("draw_busy", int'(busy), 1);
      check("draw_valid_low", int'(moleValid), 0);
      for (int i = 0; i < MT + 4; i++) begin
        if (sb.size() == 0) break;
        @(negedge clk);
        #1;
      end
      if (sb.size() != 0) begin
        check("mole_timeout", sb.size(), 0);
        sb.delete();
      end
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin : stim
    int lat;
    drop_model();
    #1 resetN = 1'b0;
    #1;
    check("reset_outputs", int'({holeIdx, holeLed, moleValid, moleCount, busy, done}), 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Idle ignores requests
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("idle_ignores_tick", int'(busy | moleValid), 0);

    // Basic draw and hit
    do_start();
    issue(0);
    do_hit();

    // Collisions
    issue(2);
    check("tick_sample_once", int'(moleCount), 2);
    issue(3);
    @(negedge clk);
    start = 1'b1; tick = 1'b1; m_cnt = 0;
    @(negedge clk);
    start = 1'b0; tick = 1'b0;
    check("start_tick_count", int'(moleCount), 0);
    check("start_tick_wait", int'(busy | moleValid), 0);
    issue(1);

    // Reset mid-SHOW
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("reset_mid_show", int'({holeIdx, holeLed, moleValid, moleCount, busy, done}), 0);
    drop_model();
    @(negedge clk);
    resetN = 1'b1;
    do_start();
    issue(0);

    // Full round, then ticks after the round are ignored
    do_start();
    for (int r = 0; r < MM; r++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      issue($urandom_range(0, 2));
    end
    check("round_count", int'(moleCount), MM);
    issue(0);
    issue(0);
    issue(1);

    // Long randomized run with restarts
    for (int r = 0; r < 1000; r++) begin
      if (m_cnt == MM) do_start();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) do_hit();
    end
    for (int h = 0; h < NH; h++) check("hole_seen", int'(seen[h]), 1);

    // Single-hole instance: fallback must always land on hole 0 within two draw cycles
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk); tick1 = 1'b1;
      @(negedge clk); tick1 = 1'b0;
      lat = 1;
      while (!moleValid1 && lat < 5) begin
        @(negedge clk);
        lat++;
      end
      check("one_valid", int'(moleValid1), 1);
      check("one_within_two_draws", int'(lat <= 3), 1);
      check("one_idx", int'(holeIdx1), 0);
      check("one_led", int'(holeLed1), 1);
      @(negedge clk); hit1 = 1'b1;
      @(negedge clk); hit1 = 1'b0;
    end
    check("one_count", int'(moleCount1), 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
